// File: rtl/simmem_pkg.sv
// Shared widths and slot record for the release scheduler.
package simmem_pkg;

   localparam int IDWidth         = 8;
   localparam int DelayWidth      = 8;
   localparam int NumSlotsDefault = 32;

   typedef struct packed {
      logic                  valid;
      logic [IDWidth-1:0]    id;
      logic [DelayWidth-1:0] cnt;
   } release_slot_t;

endpackage

// File: rtl/simmem_lowest_index_finder.sv
// Priority encoder: lowest set request bit as one-hot, binary index and found flag.
module simmem_lowest_index_finder #(
   parameter int N = 32,
   localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   output logic [N-1:0]    onehot,
   output logic [IdxW-1:0] idx,
   output logic            found
);

   always_comb begin
      idx = '0;
      // Descending scan so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = i[IdxW-1:0];
      end
   end

   assign onehot = req & (~req + N'(1));
   assign found  = |req;

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-slot latency countdown that raises release_en for IDs with an expired slot
// and retires one expired slot per completed bank release.
module simmem_release_scheduler
   import simmem_pkg::*;
#(
   parameter int NumSlots = NumSlotsDefault,
   localparam int NumIds  = 2 ** IDWidth,
   localparam int OccW    = $clog2(NumSlots) + 1,
   localparam int SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  alloc_valid_i,
   output logic                  alloc_ready_o,
   input  logic [IDWidth-1:0]    alloc_id_i,
   input  logic [DelayWidth-1:0] alloc_delay_i,
   output logic [NumIds-1:0]     release_en_o,
   input  logic                  released_valid_i,
   input  logic [IDWidth-1:0]    released_id_i,
   output logic [OccW-1:0]       occupancy_o,
   output logic                  err_o
);

   release_slot_t slots [NumSlots];
   logic [OccW-1:0] occupancy_q;
   logic err_q;

   logic [NumSlots-1:0] free_vec, match_vec;
   logic [NumSlots-1:0] free_onehot, match_onehot;
   logic [SlotIdxW-1:0] free_idx, match_idx;
   logic free_found, match_found;
   logic alloc_fire, retire;
   logic unused_finder_outs;

   always_comb begin
      free_vec     = '0;
      match_vec    = '0;
      release_en_o = '0;
      for (int i = 0; i < NumSlots; i++) begin
         free_vec[i]  = ~slots[i].valid;
         match_vec[i] = slots[i].valid && (slots[i].cnt == '0) &&
                        (slots[i].id == released_id_i);
         if (slots[i].valid && (slots[i].cnt == '0)) release_en_o[slots[i].id] = 1'b1;
      end
   end

   simmem_lowest_index_finder #(.N(NumSlots)) u_free_finder (
      .req    (free_vec),
      .onehot (free_onehot),
      .idx    (free_idx),
      .found  (free_found)
   );

   simmem_lowest_index_finder #(.N(NumSlots)) u_match_finder (
      .req    (match_vec),
      .onehot (match_onehot),
      .idx    (match_idx),
      .found  (match_found)
   );

   assign unused_finder_outs = ^{free_idx, match_onehot};

   assign alloc_ready_o = free_found;
   assign alloc_fire    = alloc_valid_i & free_found;
   assign retire        = released_valid_i & match_found;

   // The allocation target is drawn from slots free before the edge, so it can
   // never coincide with the slot being retired in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumSlots; i++) slots[i] <= '0;
         occupancy_q <= '0;
         err_q       <= 1'b0;
      end else begin
         for (int i = 0; i < NumSlots; i++) begin
            if (slots[i].valid && (slots[i].cnt != '0)) slots[i].cnt <= slots[i].cnt - 1'b1;
            if (retire && (match_idx == i[SlotIdxW-1:0])) slots[i].valid <= 1'b0;
            if (alloc_fire && free_onehot[i]) begin
               slots[i].valid <= 1'b1;
               slots[i].id    <= alloc_id_i;
               slots[i].cnt   <= alloc_delay_i;
            end
         end
         case ({alloc_fire, retire})
            2'b10:   occupancy_q <= occupancy_q + OccW'(1);
            2'b01:   occupancy_q <= occupancy_q - OccW'(1);
            default: occupancy_q <= occupancy_q;
         endcase
         if (released_valid_i && !match_found) err_q <= 1'b1;
      end
   end

   assign occupancy_o = occupancy_q;
   assign err_o       = err_q;

endmodule
